// File: rtl/arb_req_agent_if.sv
// Requester-agent bundle: local job offer side plus the arbiter req/grant lane.
// Latency: n/a (wires only).
// Backpressure: job_valid/job_ready handshake on the job side; grant throttles beats.
//
// Signals:
//   job_valid, job_len, job_ready : job offer from local logic (push = valid & ready)
//   grant, req, beat              : arbiter lane; beat = req & grant
//   done, timeout_err             : per-job completion / abort pulses
//   pending, busy                 : queue occupancy and agent activity status
interface arb_req_agent_if #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic             grant;
  logic             req;
  logic             beat;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] pending;
  logic             busy;

  // master: the agent itself
  modport master (
    input  job_valid, job_len, grant,
    output job_ready, req, beat, done, timeout_err, pending, busy
  );

  // slave: local logic / arbiter model facing the agent
  modport slave (
    output job_valid, job_len, grant,
    input  job_ready, req, beat, done, timeout_err, pending, busy
  );
endinterface

// File: rtl/arb_req_agent.sv
// Requester-side arbiter agent: queues burst jobs, holds req until all beats are granted.
// Latency: job accepted at edge E0 pops at E1 (req=1 after E1); done/timeout_err coincide with the deciding cycle.
// Backpressure: job_ready drops when the queue holds DEPTH jobs (no bypass); a starved job aborts after TIMEOUT cycles.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : arb_req_agent_if.master (job offer, req/grant lane, done/timeout_err, pending/busy)
module arb_req_agent #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  arb_req_agent_if.master   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // Job queue
  // ---------------------------------------------------------------------------
  logic [LEN_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  state_t           state;
  logic             req_reg;
  logic [LEN_W-1:0] rem;
  logic [WD_W-1:0]  wdog;

  logic job_ready;
  logic push;
  logic pop;
  logic beat;

  // Ready comes straight from the registered count, so a pop in the same
  // cycle never opens a slot early.
  assign job_ready = (count != FULL_CNT);
  assign push      = bus.job_valid & job_ready;
  assign pop       = (state == IDLE) && (count != '0);

  // Storage has no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.job_len;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  // req_reg is high exactly while in REQ, so any grant seen in IDLE/GAP is a
  // stale registered grant from the arbiter and produces no beat.
  assign beat = req_reg & bus.grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_reg <= 1'b0;
      rem     <= '0;
      wdog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            rem     <= mem[rd_ptr];
            wdog    <= '0;
            req_reg <= 1'b1;
            state   <= REQ;
          end
        end

        REQ: begin
          if (bus.grant) begin
            // A beat always beats the watchdog, even on the limit cycle.
            if (rem == '0) begin
              req_reg <= 1'b0;
              state   <= GAP;
            end else begin
              rem  <= rem - LEN_W'(1);
              wdog <= '0;
            end
          end else if (wdog == WD_LIMIT) begin
            // Abort: remaining beats are discarded.
            rem     <= '0;
            wdog    <= '0;
            req_reg <= 1'b0;
            state   <= GAP;
          end else begin
            // Covers preemption too: rem holds while the grant is withdrawn.
            wdog <= wdog + WD_W'(1);
          end
        end

        GAP: begin
          // One req-low cycle so the arbiter sees the release.
          state <= IDLE;
        end

        default: begin
          req_reg <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // done/timeout_err must line up with the deciding cycle itself, so they are
  // decoded from registered state and the live grant rather than registered.
  // They cannot overlap: one needs grant=1, the other grant=0.
  assign bus.req         = req_reg;
  assign bus.beat        = beat;
  assign bus.done        = beat && (rem == '0);
  assign bus.timeout_err = req_reg && !bus.grant && (wdog == WD_LIMIT);
  assign bus.job_ready   = job_ready;
  assign bus.pending     = count;
  assign bus.busy        = (state != IDLE);

`ifndef SYNTHESIS
  a_done_terr_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.done && bus.timeout_err));
  a_req_in_req     : assert property (@(posedge clk) disable iff (!rst_n)
    req_reg == (state == REQ));
`endif

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent: hand-computed per-cycle expectations.
// Latency: n/a.
// Backpressure: grant and job_valid driven per cycle from directed vectors.
module tb_arb_req_agent;

  localparam int DEPTH   = 4;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst_n;

  arb_req_agent_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus_i ();

  arb_req_agent #(
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, drive this cycle's inputs, let combinational outputs settle.
  task automatic drive(input logic g, input logic jv, input logic [LEN_W-1:0] jl);
    @(posedge clk);
    #1;
    bus_i.grant     = g;
    bus_i.job_valid = jv;
    bus_i.job_len   = jl;
    #1;
  endtask

  task automatic lane(input string tag, input int er, input int eb, input int ed, input int et);
    chk({tag, "_req"},  int'(bus_i.req),         er);
    chk({tag, "_beat"}, int'(bus_i.beat),        eb);
    chk({tag, "_done"}, int'(bus_i.done),        ed);
    chk({tag, "_terr"}, int'(bus_i.timeout_err), et);
  endtask

  task automatic occ(input string tag, input int ep, input int erdy, input int ebusy);
    chk({tag, "_pend"}, int'(bus_i.pending),   ep);
    chk({tag, "_rdy"},  int'(bus_i.job_ready), erdy);
    chk({tag, "_busy"}, int'(bus_i.busy),      ebusy);
  endtask

  logic pre_g [6];

  initial begin
    pre_g = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // ---------------- reset ----------------
    rst_n           = 1'b0;
    bus_i.grant     = 1'b1;
    bus_i.job_valid = 1'b0;
    bus_i.job_len   = '0;
    #12;
    lane("rst", 0, 0, 0, 0);
    chk("rst_pend", int'(bus_i.pending), 0);
    chk("rst_busy", int'(bus_i.busy), 0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus_i.grant = 1'b0;
    #1;
    occ("rel", 0, 1, 0);

    // ---------------- single job, len=2 ----------------
    drive(0, 1, 4'd2);  occ("s_off", 0, 1, 0);
    drive(0, 0, 4'd0);  occ("s_q", 1, 1, 0);  lane("s_q", 0, 0, 0, 0);
    drive(0, 0, 4'd0);  occ("s_r0", 0, 1, 1); lane("s_r0", 1, 0, 0, 0);
    drive(1, 0, 4'd0);  lane("s_b1", 1, 1, 0, 0);
    drive(1, 0, 4'd0);  lane("s_b2", 1, 1, 0, 0);
    drive(1, 0, 4'd0);  lane("s_b3", 1, 1, 1, 0);
    drive(0, 0, 4'd0);  lane("s_gap", 0, 0, 0, 0); chk("s_gap_busy", int'(bus_i.busy), 1);
    drive(0, 0, 4'd0);  lane("s_idle", 0, 0, 0, 0); chk("s_idle_busy", int'(bus_i.busy), 0);

    // ---------------- stale grant after len=0 burst ----------------
    drive(0, 1, 4'd0);
    drive(0, 0, 4'd0);  chk("st_q_pend", int'(bus_i.pending), 1);
    drive(0, 0, 4'd0);  lane("st_r0", 1, 0, 0, 0);
    drive(1, 0, 4'd0);  lane("st_b1", 1, 1, 1, 0);
    drive(1, 0, 4'd0);  lane("st_gap", 0, 0, 0, 0);
    drive(1, 0, 4'd0);  lane("st_idle", 0, 0, 0, 0); chk("st_idle_busy", int'(bus_i.busy), 0);
    drive(1, 0, 4'd0);  lane("st_idle2", 0, 0, 0, 0); chk("st_idle2_busy", int'(bus_i.busy), 0);

    // ---------------- preemption, len=3 ----------------
    drive(0, 1, 4'd3);
    drive(0, 0, 4'd0);
    drive(0, 0, 4'd0);  lane("pr_r0", 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(pre_g[i], 0, 4'd0);
      lane($sformatf("pr_c%0d", i), 1, int'(pre_g[i]), (i == 5) ? 1 : 0, 0);
    end
    drive(0, 0, 4'd0);  lane("pr_gap", 0, 0, 0, 0);
    drive(0, 0, 4'd0);  chk("pr_idle_busy", int'(bus_i.busy), 0);

    // ---------------- beat on watchdog limit cycle wins, wdog clears ----------------
    drive(0, 1, 4'd1);
    drive(0, 0, 4'd0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      drive((k == TIMEOUT) ? 1'b1 : 1'b0, 0, 4'd0);
      lane($sformatf("wb_k%0d", k), 1, (k == TIMEOUT) ? 1 : 0, 0, 0);
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      drive((k == TIMEOUT) ? 1'b1 : 1'b0, 0, 4'd0);
      lane($sformatf("wb_j%0d", k), 1, (k == TIMEOUT) ? 1 : 0, (k == TIMEOUT) ? 1 : 0, 0);
    end
    drive(0, 0, 4'd0);  lane("wb_gap", 0, 0, 0, 0);
    drive(0, 0, 4'd0);  chk("wb_idle_busy", int'(bus_i.busy), 0);

    // ---------------- starvation, len=5, second job queued ----------------
    drive(0, 1, 4'd5);  chk("sv_p0", int'(bus_i.pending), 0);
    drive(0, 1, 4'd0);  chk("sv_p1", int'(bus_i.pending), 1); lane("sv_q", 0, 0, 0, 0);
    drive(0, 0, 4'd0);  chk("sv_pushpop", int'(bus_i.pending), 1); lane("sv_k1", 1, 0, 0, 0);
    for (int k = 2; k <= TIMEOUT; k++) begin
      drive(0, 0, 4'd0);
      lane($sformatf("sv_k%0d", k), 1, 0, 0, (k == TIMEOUT) ? 1 : 0);
    end
    drive(0, 0, 4'd0);  lane("sv_gap", 0, 0, 0, 0); occ("sv_gap", 1, 1, 1);
    drive(0, 0, 4'd0);  lane("sv_idle", 0, 0, 0, 0); occ("sv_idle", 1, 1, 0);
    drive(0, 0, 4'd0);  lane("sv_j2", 1, 0, 0, 0); occ("sv_j2", 0, 1, 1);
    drive(1, 0, 4'd0);  lane("sv_j2b", 1, 1, 1, 0);
    drive(0, 0, 4'd0);  lane("sv_j2gap", 0, 0, 0, 0);
    drive(0, 0, 4'd0);  chk("sv_end_busy", int'(bus_i.busy), 0);

    // ---------------- FIFO full while the head job is starved ----------------
    drive(0, 1, 4'd3);
    drive(0, 0, 4'd0);  chk("ff_p1", int'(bus_i.pending), 1);
    drive(0, 0, 4'd0);  lane("ff_k1", 1, 0, 0, 0); chk("ff_k1_pend", int'(bus_i.pending), 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 4'd3);
      chk($sformatf("ff_push%0d_pend", i), int'(bus_i.pending), i);
      chk($sformatf("ff_push%0d_rdy", i), int'(bus_i.job_ready), (i < 4) ? 1 : 0);
    end
    drive(0, 0, 4'd0);  occ("ff_k7", 4, 0, 1);
    for (int k = 8; k <= TIMEOUT; k++) begin
      drive(0, 0, 4'd0);
      lane($sformatf("ff_k%0d", k), 1, 0, 0, (k == TIMEOUT) ? 1 : 0);
    end
    drive(0, 0, 4'd0);  lane("ff_gap", 0, 0, 0, 0); occ("ff_gap", 4, 0, 1);
    drive(0, 0, 4'd0);  occ("ff_idle", 4, 0, 0);
    drive(0, 0, 4'd0);  occ("ff_pop", 3, 1, 1); lane("ff_pop", 1, 0, 0, 0);

    // ---------------- reset mid-burst ----------------
    drive(1, 0, 4'd0);  lane("rm_b1", 1, 1, 0, 0);
    drive(1, 0, 4'd0);  lane("rm_b2", 1, 1, 0, 0);
    @(posedge clk);
    #1;
    bus_i.grant = 1'b1;
    rst_n       = 1'b0;
    #1;
    lane("rm_rst", 0, 0, 0, 0);
    occ("rm_rst", 0, 1, 0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus_i.grant = 1'b0;
    #1;
    occ("rm_rel", 0, 1, 0);
    drive(0, 0, 4'd0);  lane("rm_after", 0, 0, 0, 0); occ("rm_after", 0, 1, 0);
    drive(0, 0, 4'd0);  chk("rm_after2_req", int'(bus_i.req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
